// File: rtl/drive_arbiter.sv
// Frame-synchronous arbiter sharing the two servo drive channels between a line-following
// requester (A) and an override requester (B); commands change only at frame boundaries.
module drive_arbiter #(
   parameter int unsigned PERIOD      = 2_000_000,
   parameter int unsigned MIN_HOLD    = 4,
   parameter int unsigned WDOG_FRAMES = 25
) (
   input  logic        clk,
   input  logic        reset,
   output logic [20:0] count_out,
   output logic        frame_last,
   input  logic        a_valid,
   input  logic [3:0]  a_cmd,
   output logic        a_ack,
   input  logic        b_valid,
   input  logic [3:0]  b_cmd,
   output logic        b_ack,
   output logic        motor_l_reset,
   output logic        motor_l_direction,
   output logic        motor_r_reset,
   output logic        motor_r_direction,
   output logic [1:0]  grant,
   output logic        fault
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StGrantA = 2'd1;
   localparam logic [1:0] StGrantB = 2'd2;
   localparam logic [1:0] StFault  = 2'd3;

   localparam logic [3:0] StopCmd = 4'b1010;

   localparam int unsigned HoldW = $clog2(MIN_HOLD + 1);
   localparam int unsigned MissW = $clog2(WDOG_FRAMES + 1);

   localparam logic [HoldW-1:0] HoldInit   = HoldW'(MIN_HOLD - 1);
   localparam logic [MissW-1:0] MissLast   = MissW'(WDOG_FRAMES - 1);
   localparam logic [20:0]      PeriodLast = 21'(PERIOD - 1);

   logic [20:0]      count_q;
   logic [1:0]       state_q, state_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [HoldW-1:0] hold_q, hold_d, hold_dec;
   logic [MissW-1:0] miss_q, miss_d;
   logic             a_ack_q, a_ack_d;
   logic             b_ack_q, b_ack_d;
   logic             take_a, take_b;

   assign frame_last = (count_q == PeriodLast);
   assign hold_dec   = (hold_q == '0) ? '0 : hold_q - HoldW'(1);

   // Ownership changes are decided here; the refresh/miss path is handled below.
   always_comb begin
      take_a = 1'b0;
      take_b = 1'b0;
      unique case (state_q)
         StIdle: begin
            take_b = b_valid;
            take_a = !b_valid && a_valid;
         end
         StGrantA: take_b = b_valid && (hold_q == '0);
         StGrantB: take_a = !b_valid && a_valid && (hold_q == '0);
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      hold_d  = hold_q;
      miss_d  = miss_q;
      a_ack_d = 1'b0;
      b_ack_d = 1'b0;
      if (frame_last) begin
         if (take_a || take_b) begin
            state_d = take_b ? StGrantB : StGrantA;
            cmd_d   = take_b ? b_cmd : a_cmd;
            hold_d  = HoldInit;
            miss_d  = '0;
            a_ack_d = take_a;
            b_ack_d = take_b;
         end else if (state_q == StGrantA || state_q == StGrantB) begin
            hold_d = hold_dec;
            if (state_q == StGrantA && a_valid) begin
               cmd_d   = a_cmd;
               a_ack_d = 1'b1;
               miss_d  = '0;
            end else if (state_q == StGrantB && b_valid) begin
               cmd_d   = b_cmd;
               b_ack_d = 1'b1;
               miss_d  = '0;
            end else if (miss_q == MissLast) begin
               state_d = StFault;
               cmd_d   = StopCmd;
               hold_d  = '0;
               miss_d  = '0;
            end else begin
               miss_d = miss_q + MissW'(1);
            end
         end else if (state_q == StFault && !a_valid && !b_valid) begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         state_q <= StIdle;
         cmd_q   <= StopCmd;
         hold_q  <= '0;
         miss_q  <= '0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
      end else begin
         count_q <= frame_last ? '0 : count_q + 21'd1;
         state_q <= state_d;
         cmd_q   <= cmd_d;
         hold_q  <= hold_d;
         miss_q  <= miss_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
      end
   end

   assign count_out         = count_q;
   assign a_ack             = a_ack_q;
   assign b_ack             = b_ack_q;
   assign motor_l_reset     = cmd_q[3];
   assign motor_l_direction = cmd_q[2];
   assign motor_r_reset     = cmd_q[1];
   assign motor_r_direction = cmd_q[0];
   assign grant             = {state_q == StGrantB, state_q == StGrantA};
   assign fault             = (state_q == StFault);

endmodule

// File: doc/drive_arbiter.md
# drive_arbiter

Frame-synchronous arbiter that shares the two servo drive channels between two command sources: the line-following controller (requester A) and an override/mission source (requester B). It owns the servo frame timebase and latches a winning motor command only at frame boundaries, so drive outputs never change mid-pulse. It enforces a minimum grant hold and stops both motors through a watchdog when the owner stops refreshing.

## Interface
- PERIOD, 2_000_000, clock cycles per servo frame; legal range 4..2^21.
- MIN_HOLD, 4, frames a new owner keeps the grant before it can be preempted; at least 1.
- WDOG_FRAMES, 25, consecutive frames the owner may go unrefreshed before a forced stop; at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- count_out  out  21  frame timebase, 0..PERIOD-1.
- frame_last  out  1  high while count_out == PERIOD-1. This is the decision cycle.
- a_valid  in  1  requester A holds a command.
- a_cmd  in  4  {l_reset, l_dir, r_reset, r_dir}.
- a_ack  out  1  one-cycle pulse when a_cmd was latched.
- b_valid, b_cmd, b_ack  same as A, for requester B (higher priority).
- motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction  out  1 each  registered drive command.
- grant  out  2  one-hot owner: 01 = A, 10 = B, 00 = none.
- fault  out  1  high while in FAULT.

## Operation
- Timebase behaviour:
  - count_out increments every cycle and wraps from PERIOD-1 to 0.
  - All arbitration happens only in the decision cycle. Registered results appear when count_out = 0.
- STOP command is 4'b1010: both motors held in reset, both direction bits 0.
- IDLE:
  - Outputs STOP, grant 00.
  - At decision: if b_valid, go to GRANT_B. Otherwise, if a_valid, go to GRANT_A. Otherwise stay in IDLE.
- Entering GRANT_x:
  - Latch x_cmd.
  - hold_cnt = MIN_HOLD-1.
  - miss_cnt = 0.
  - Pulse x_ack.
- GRANT_A at decision, in priority order:
  1. If b_valid and hold_cnt == 0, switch to GRANT_B, even if a_valid.
  2. Else if a_valid, latch a_cmd, pulse a_ack, miss_cnt = 0.
  3. Else keep the last command and increment miss_cnt.
- GRANT_B at decision, symmetric, with one exception: A preempts B only when b_valid = 0, a_valid = 1 and hold_cnt == 0.
- hold_cnt decrements at every decision in a GRANT state, saturating at 0.
- Watchdog: if miss_cnt reaches WDOG_FRAMES at a decision, go to FAULT instead of keeping the command. This check takes precedence over staying in the state, but not over a legal switch to the other requester.
- FAULT:
  - Outputs STOP, grant 00, fault = 1.
  - Lasts at least one full frame.
  - At a decision cycle inside FAULT: if a_valid = b_valid = 0, go to IDLE. Otherwise remain in FAULT.
  - No acks are issued while in FAULT.
- Handshake:
  - A requester must hold x_valid and x_cmd stable until it sees x_ack.
  - A non-acked request at a decision cycle is simply not served. It may be held or dropped.
  - The sampled command is the value during the decision cycle.
- Reset, at any point including mid-frame:
  - count_out = 0, IDLE, outputs STOP.
  - grant = 00, acks = 0, fault = 0, hold_cnt = 0, miss_cnt = 0.

## Timing
- Latency:
  - A command valid during the decision cycle appears on the motor outputs at the next edge, when count_out = 0.
  - x_ack is high for exactly that same cycle (count_out = 0).
- Motor outputs, grant and fault are registered and change only on the edge into count_out = 0, or on reset.
- frame_last is a decode of count_out and is high for one cycle per frame.
- Worst-case latency for a request is PERIOD cycles plus the hold remainder: (MIN_HOLD-1)·PERIOD when blocked by a fresh grant.
- miss_cnt and hold_cnt are wide enough for their parameters. Neither counter wraps.

## Test plan
Parameters for the bench: PERIOD = 16, MIN_HOLD = 2, WDOG_FRAMES = 3.
- **Reset:** assert reset for 3 cycles mid-frame -> count_out = 0, motors = 1010, grant = 00, fault = 0, no acks.
- **Single requester:** a_valid = 1, a_cmd = 0101 from cycle 0 -> at cycle 16 motors = 0101, grant = 01, a_ack pulses for one cycle; cmd 0011 presented at cycle 20 appears at cycle 32 with a second ack.
- **Simultaneous request from IDLE:** a_valid = b_valid = 1, b_cmd = 1100 -> cycle 16 grant = 10, motors = 1100, b_ack only.
- **Hold enforcement:** A granted at cycle 16, b_valid raised at cycle 20 -> still grant = 01 at cycle 32, switch to grant = 10 with b_ack at cycle 48.
- **Watchdog:** A granted at cycle 16 then a_valid dropped -> last command held at cycles 32 and 48, FAULT at cycle 64 (motors 1010, fault = 1), IDLE at cycle 80 with fault = 0.
- **Fault with live request:** repeat the watchdog case but raise b_valid at cycle 60 -> grant switches to B at cycle 64 and no fault; with b_valid raised only at cycle 70, FAULT persists until both valids are low at a decision cycle.
